pool_sched_ctrl: RTL
====================

Name: pool_sched_ctrl

Overview:
- Sequencer that walks a square feature map in non-overlapping pooling windows (stride = window size).
- Per window: fetches pixels from the image memory, presents them packed to the external pool_window datapath, and writes each pooled result to the output memory.
- Sits between the layer controller (start/done) and the image/output memories.

Parameters:
DW, 16, pixel width (signed fixed point)
N_MAX, 32, maximum image dimension
W_MAX, 5, maximum window dimension
AW, 10, memory address width (log2 N_MAX*N_MAX)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; accepted only in IDLE
img_size  in  16  image dimension; sampled on the accepted start
window_size  in  16  window dimension; sampled on the accepted start
busy  out  1  high in CHECK..WRITE
done  out  1  one-cycle pulse in DONE
cfg_err  out  1  sticky; cleared on the next accepted start
rd_en  out  1  image memory read strobe
rd_addr  out  AW  image read address
rd_data  in  DW  valid one cycle after rd_en
win_data  out  W_MAX*W_MAX x DW  packed window; slot f = r*ws+c; unused slots 0
win_size  out  16  latched window_size, fed to pool_window
win_valid  out  1  one-cycle, in EMIT
pool_result  in  DW  combinational pool_window output; sampled in EMIT
wr_en  out  1  output memory write strobe
wr_addr  out  AW  output index oy*n_out+ox
wr_data  out  DW  registered pool_result

Behaviour:
- Reset: state=IDLE; all outputs, counters and window slots are 0.
- Reset mid-operation aborts immediately; no partial write occurs.
- n_out = floor(img/ws). Trailing rows/cols beyond n_out*ws are never read.
- All address arithmetic is unsigned, truncated to AW bits.
- States: IDLE, CHECK, CLEAR, FETCH, DRAIN, EMIT, WRITE, DONE.
- IDLE -> CHECK on start; latch cfg. start outside IDLE is ignored.
- CHECK: invalid if ws==0, ws>W_MAX, img==0, img>N_MAX, or ws>img.
  - Invalid: set cfg_err, go to DONE.
  - Valid: go to CLEAR.
- CLEAR: zero all window slots; k=0.
- FETCH: one read per cycle, r-major then c, for k=0..ws²-1.
  - rd_addr = (oy*ws+r)*img + ox*ws + c.
  - Data returned in the next cycle is written to slot k-1.
  - After the last read -> DRAIN.
- DRAIN: capture the final pixel.
- EMIT: win_valid=1; register pool_result.
- WRITE: wr_en=1 with wr_addr and wr_data. Advance ox; on ox wrap, advance oy.
  - More windows -> CLEAR; otherwise -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Timing, with start sampled at edge E0:
  - done is high in the cycle after edge E0+1+n_out²·(ws²+4).
  - On config error: done follows edge E0+1, with no rd_en/wr_en.
- Reads and writes never occur in the same cycle.

Optional Feature:
POOL_SCHED_PERF_EN
- Defined: adds output cycle_cnt [31:0]. Cleared on an accepted start, increments every busy cycle, holds after done, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package pool_pkg: DW, N_MAX, W_MAX, AW, and the state enum typedef pool_sched_state_t.
- Sub-module pool_addr_gen: combinational rd_addr/wr_addr from (oy, ox, r, c, ws, img, n_out).
- pool_window stays external.

Test Plan:
- Image 4x4, pixel[i]=i, ws=2.
  - Window 0: rd_addr 0,1,4,5.
  - Writes to wr_addr 0..3.
  - win_data slots 4..24 are 0.
  - done after edge E0+33.
- Image 7x7, ws=3: n_out=2, exactly 4 writes; addresses 6, 13, 20 and 42..48 are never read.
- Invalid configs:
  - ws=0: cfg_err=1, done after edge E0+1, no rd_en/wr_en.
  - ws=6: same response.
  - A following valid start clears cfg_err.
- Reset asserted mid-FETCH: outputs 0 immediately; wr_en never pulses. The next start with the 4x4 test completes correctly.
- start re-pulsed while busy with img=8, ws=4: ignored; the original 4x4/ws=2 run completes with 4 writes.
- Perf (POOL_SCHED_PERF_EN defined): 4x4 image, ws=2 gives cycle_cnt=33 at done, held afterwards.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared sizing constants and FSM state encoding for the pooling window sequencer.
package pool_pkg;

    localparam int DW    = 16;
    localparam int N_MAX = 32;
    localparam int W_MAX = 5;
    localparam int AW    = 10;
    localparam int NSLOT = W_MAX * W_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_EMIT,
        S_WRITE,
        S_DONE
    } pool_sched_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Image read and output write address generation, unsigned and wrapped to AW bits.
// Latency: combinational. Backpressure: none.
module pool_addr_gen
    import pool_pkg::*;
(
    input  logic [15:0]   oy,
    input  logic [15:0]   ox,
    input  logic [15:0]   r,
    input  logic [15:0]   c,
    input  logic [15:0]   ws,
    input  logic [15:0]   img,
    input  logic [15:0]   n_out,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr
);

    logic [AW-1:0] row;

    // Truncating operands first gives the same result modulo 2^AW.
    assign row     = AW'(oy) * AW'(ws) + AW'(r);
    assign rd_addr = row * AW'(img) + AW'(ox) * AW'(ws) + AW'(c);
    assign wr_addr = AW'(oy) * AW'(n_out) + AW'(ox);

endmodule

// File: rtl/pool_sched_ctrl.sv
// Walks a square image in non-overlapping pooling windows: fetch, emit to pool_window, write result.
// Latency: done follows start by 1 + n_out^2*(ws^2+4) cycles; 1 cycle on a bad config.
// Backpressure: none; fixed-latency memories. POOL_SCHED_PERF_EN adds the cycle_cnt busy counter.
module pool_sched_ctrl
    import pool_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         img_size,
    input  logic [15:0]         window_size,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic                rd_en,
    output logic [AW-1:0]       rd_addr,
    input  logic [DW-1:0]       rd_data,
    output logic [NSLOT*DW-1:0] win_data,
    output logic [15:0]         win_size,
    output logic                win_valid,
    input  logic [DW-1:0]       pool_result,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [DW-1:0]       wr_data
`ifdef POOL_SCHED_PERF_EN
    ,
    output logic [31:0]         cycle_cnt
`endif
);

    pool_sched_state_t state, nxt;

    logic [15:0]   img_q, ws_q, n_out;
    logic [15:0]   ox, oy, r, c, k;
    logic          cap_en;
    logic [4:0]    cap_idx;
    logic [DW-1:0] slot [NSLOT];
    logic [DW-1:0] res_q;
    logic [AW-1:0] ag_rd, ag_wr;
    logic          cfg_ok, last_read, last_col, last_ox, last_oy;

    assign cfg_ok = (ws_q != 16'd0) && (ws_q <= 16'(W_MAX)) &&
                    (img_q != 16'd0) && (img_q <= 16'(N_MAX)) && (ws_q <= img_q);

    assign last_read = (k == ws_q * ws_q - 16'd1);
    assign last_col  = (c == ws_q - 16'd1);
    assign last_ox   = (ox == n_out - 16'd1);
    assign last_oy   = (oy == n_out - 16'd1);

    pool_addr_gen u_addr (
        .oy      (oy),
        .ox      (ox),
        .r       (r),
        .c       (c),
        .ws      (ws_q),
        .img     (img_q),
        .n_out   (n_out),
        .rd_addr (ag_rd),
        .wr_addr (ag_wr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt       = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        win_valid = 1'b0;
        wr_en     = 1'b0;
        case (state)
            S_IDLE:  if (start) nxt = S_CHECK;
            S_CHECK: begin
                busy = 1'b1;
                nxt  = cfg_ok ? S_CLEAR : S_DONE;
            end
            S_CLEAR: begin
                busy = 1'b1;
                nxt  = S_FETCH;
            end
            S_FETCH: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_read) nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                nxt  = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                win_valid = 1'b1;
                nxt       = S_WRITE;
            end
            S_WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                nxt   = (last_ox && last_oy) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                done = 1'b1;
                nxt  = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            img_q   <= '0;
            ws_q    <= '0;
            n_out   <= '0;
            ox      <= '0;
            oy      <= '0;
            r       <= '0;
            c       <= '0;
            k       <= '0;
            cap_en  <= 1'b0;
            cap_idx <= '0;
            cfg_err <= 1'b0;
            res_q   <= '0;
            for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
        end else begin
            // Memory data lands one cycle after its read; capture into the slot of that read.
            cap_en  <= (state == S_FETCH);
            cap_idx <= k[4:0];
            if (cap_en) slot[cap_idx] <= rd_data;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        img_q   <= img_size;
                        ws_q    <= window_size;
                        cfg_err <= 1'b0;
                        ox      <= '0;
                        oy      <= '0;
                    end
                end
                S_CHECK: begin
                    if (cfg_ok) n_out   <= img_q / ws_q;
                    else        cfg_err <= 1'b1;
                end
                S_CLEAR: begin
                    for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
                    k <= '0;
                    r <= '0;
                    c <= '0;
                end
                S_FETCH: begin
                    k <= k + 16'd1;
                    if (last_col) begin
                        c <= '0;
                        r <= r + 16'd1;
                    end else begin
                        c <= c + 16'd1;
                    end
                end
                S_EMIT: res_q <= pool_result;
                S_WRITE: begin
                    if (last_ox) begin
                        ox <= '0;
                        oy <= oy + 16'd1;
                    end else begin
                        ox <= ox + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        win_data = '0;
        for (int f = 0; f < NSLOT; f++) win_data[f*DW +: DW] = slot[f];
    end

    assign win_size = ws_q;
    assign rd_addr  = rd_en ? ag_rd : '0;
    assign wr_addr  = wr_en ? ag_wr : '0;
    assign wr_data  = res_q;

`ifdef POOL_SCHED_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                         cycle_cnt <= '0;
        else if (state == S_IDLE && start) cycle_cnt <= '0;
        else if (busy)                     cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

endmodule
